// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: a Moore FSM that steps each instruction
// through fetch/decode/execute/memory/write-back, traps on bad opcodes and counts retirements.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   alu_zero,
  input  logic                   alu_neg,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_GTZ = 2'd2
  } br_kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e                 state_q, state_d;
  br_kind_e               br_kind_q, br_kind_d;
  logic                   is_store_q, is_store_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   retire;
  logic                   taken;

  // State, latched instruction kind and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      br_kind_q  <= BR_EQ;
      is_store_q <= 1'b0;
      count_q    <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      br_kind_q  <= br_kind_d;
      is_store_q <= is_store_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic; the opcode is only looked at in DECODE, so the kind is latched there.
  always_comb begin
    state_d    = state_q;
    br_kind_d  = br_kind_q;
    is_store_d = is_store_q;
    retire     = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_R_EXEC;
          OP_LW:    begin state_d = S_MEM_ADDR; is_store_d = 1'b0; end
          OP_SW:    begin state_d = S_MEM_ADDR; is_store_d = 1'b1; end
          OP_BEQ:   begin state_d = S_BRANCH;   br_kind_d  = BR_EQ;  end
          OP_BNE:   begin state_d = S_BRANCH;   br_kind_d  = BR_NE;  end
          OP_BGTZ:  begin state_d = S_BRANCH;   br_kind_d  = BR_GTZ; end
          OP_ADDI:  state_d = S_ADDI_EXEC;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (is_store_q) state_d = S_MEM_WRITE;
        else            state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_READ;
      end
      S_MEM_WB:    begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH:    begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:      begin state_d = S_FETCH; retire = 1'b1; end
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
    if (retire) count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    else        count_d = count_q;
  end

  // Branch condition from the kind latched in DECODE; bgtz compares rs against $0.
  always_comb begin
    case (br_kind_q)
      BR_EQ:   taken = alu_zero;
      BR_NE:   taken = !alu_zero;
      BR_GTZ:  taken = !alu_zero && !alu_neg;
      default: taken = 1'b0;
    endcase
  end

  // Moore output decode; only pc_write/ir_write also look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_READ:  begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin mem_write = 1'b1; i_or_d = 1'b1; end
      S_R_EXEC:    begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_R_WB:      begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = taken;
      end
      S_JUMP:      begin pc_write = 1'b1; pc_source = 2'b10; end
      S_ADDI_EXEC: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB:   reg_write = 1'b1;
      default:     pc_write = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign illegal     = (state_q == S_TRAP);
  assign instr_count = count_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, driving mux selects, register/memory enables and the 2-bit ALUop consumed by alu_control. It sits beside the datapath, stalls on a memory ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface
- COUNT_WIDTH, 32, width of retired-instruction counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26], sampled in DECODE
- alu_zero  input  1  ALU zero flag, valid in BRANCH
- alu_neg  input  1  ALU result bit 31, valid in BRANCH
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  PC load enable (final, including branch condition)
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write  output  1 each  memory strobes, held until mem_ready
- ir_write  output  1  instruction register load
- reg_dst  output  1  write reg: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = const 4, 10 = sext imm, 11 = sext imm << 2
- alu_op  output  2  00 add, 01 sub, 10 use funct (to alu_control)
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- state  output  4  current state encoding (debug)
- illegal  output  1  sticky trap flag
- instr_count  output  COUNT_WIDTH  retired instructions

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, TRAP 13; 14/15 unreachable, go to TRAP.
- IDLE: all outputs 0; next FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write = mem_ready; stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode: 000000 R_EXEC; 100011/101011 MEM_ADDR; 000100/000101/000111 BRANCH; 001000 ADDI_EXEC; 000010 JUMP; any other TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; wait for mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write = taken; beq taken = alu_zero, bne = !alu_zero, bgtz (rt=$0) = !alu_zero & !alu_neg. Branch kind latched from opcode in DECODE. Next FETCH.
- JUMP: pc_write=1, pc_source=10; next FETCH.
- TRAP: all outputs 0 except illegal=1, state=13; stays until reset.
- Unlisted outputs are 0 in each state.
- instr_count increments by 1 on the clock edge leaving MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, or MEM_WRITE with mem_ready=1; wraps from all-ones to 0; never increments in TRAP.

## Timing
- Reset (async) forces state=IDLE, illegal=0, instr_count=0; all control outputs 0 immediately. First FETCH one cycle after reset deassertion.
- Outputs are combinational decodes of state; only pc_write and ir_write also depend on mem_ready/alu flags in the same cycle.
- Cycles per instruction with zero-wait memory (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, branch 3, jump 3; each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- Strobes held stable while waiting; no PC/IR update until mem_ready.
- Reset mid-instruction aborts it: no count increment, no write.

## Test plan
- Reset then mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1; reg_write=1, reg_dst=1 in R_WB; alu_op=10 in R_EXEC; instr_count=1.
- lw (100011) with mem_ready low 2 cycles in MEM_READ -> state 4 held 3 cycles, mem_read/i_or_d stable, then MEM_WB with mem_to_reg=1; 7 cycles total.
- beq with alu_zero=1 -> pc_write=1, pc_source=01 in BRANCH; with alu_zero=0 -> pc_write=0; bgtz with alu_neg=1 -> not taken.
- opcode 111111 -> TRAP, illegal=1 held 20 cycles, instr_count unchanged; reset -> illegal=0, state=0.
- Force instr_count to all-ones (COUNT_WIDTH=4, 15 jumps) then one jump -> instr_count=0.
- Assert reset during MEM_WRITE wait -> outputs 0 immediately, mem_write drops, instr_count=0.
